// File: rtl/pci_target_ctrl.sv
// pci_target_ctrl
//   PCI target-side controller for single and burst memory read/write cycles.
//   Decodes the address phase against a BASE_ADDR window, drives DEVSEL_N,
//   TRDY_N and STOP_N, selects the AD buffer direction (R_W), supplies the
//   read word (RD_DATA), and sequences a synchronous word memory.
//
//   Memory read timing: MEM_RE is a one-cycle strobe. MEM_RDATA must be valid
//   at the rising edge that ends the strobe cycle, which is where it is
//   captured into RD_DATA. This gives one wait state per read data phase.
//
// Parameters:
//   BASE_ADDR  base byte address of the target window
//   DEC_BITS   upper address bits compared (window = 2^(32-DEC_BITS) bytes)
//   MAX_BURST  data phases before target disconnect (disconnect build only;
//              otherwise it only bounds the saturating burst counter)
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   FRAME_N, IRDY_N     initiator control, active low
//   C_BE[3:0]           command (address phase) / byte enables, active low
//   AD_IN[31:0]         AD bus as seen by the target
//   DEVSEL_N, TRDY_N,
//   STOP_N              target control, active low
//   R_W                 1 = target drives AD with RD_DATA
//   RD_DATA[31:0]       read word for the AD buffer
//   MEM_ADDR[31:0]      word-aligned byte address to memory
//   MEM_WE, MEM_RE      one-cycle write / read strobes
//   MEM_BE[3:0]         active-high byte enables
//   MEM_WDATA[31:0]     write data
//   MEM_RDATA[31:0]     read data from memory
//
// Optional feature macro: PCI_TGT_DISCONNECT_EN
//   Defined: target disconnects with data on data phase MAX_BURST.
//   Undefined: STOP_N stays high and bursts are unbounded.

module pci_target_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEC_BITS  = 20,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME_N,
    input  logic        IRDY_N,
    input  logic [3:0]  C_BE,
    input  logic [31:0] AD_IN,
    output logic        DEVSEL_N,
    output logic        TRDY_N,
    output logic        STOP_N,
    output logic        R_W,
    output logic [31:0] RD_DATA,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic        MEM_RE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [31:0] DEC_MASK   = ~(32'hFFFF_FFFF >> DEC_BITS);
    localparam logic [3:0]  CMD_MEM_RD = 4'b0110;
    localparam logic [3:0]  CMD_MEM_WR = 4'b0111;
    localparam logic [15:0] BURST_LIM  = 16'(MAX_BURST);
`ifdef PCI_TGT_DISCONNECT_EN
    localparam logic [15:0] LAST_M1    = 16'(MAX_BURST - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY,
        S_CLAIM,
        S_WDATA,
        S_RWAIT,
        S_RDATA,
        S_TURN,
        S_DISC
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic        is_read;
    logic [15:0] cnt;

    logic        addr_hit;
    logic        cmd_rd;
    logic        cmd_wr;
    logic        xfer;
    logic        abort;
    logic [15:0] cnt_inc;

    always_comb begin
        addr_hit = ((AD_IN ^ BASE_ADDR) & DEC_MASK) == '0;
        cmd_rd   = (C_BE == CMD_MEM_RD);
        cmd_wr   = (C_BE == CMD_MEM_WR);
        xfer     = !IRDY_N && !TRDY_N;
        abort    = FRAME_N && IRDY_N;
        // Counter saturates so long unbounded bursts cannot wrap it.
        cnt_inc  = (cnt == BURST_LIM) ? cnt : cnt + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            addr      <= '0;
            is_read   <= 1'b0;
            cnt       <= '0;
            DEVSEL_N  <= 1'b1;
            TRDY_N    <= 1'b1;
            STOP_N    <= 1'b1;
            R_W       <= 1'b0;
            RD_DATA   <= '0;
            MEM_ADDR  <= '0;
            MEM_WE    <= 1'b0;
            MEM_RE    <= 1'b0;
            MEM_BE    <= '0;
            MEM_WDATA <= '0;
        end else begin
            // Strobes are single-cycle; only the states below raise them.
            MEM_WE <= 1'b0;
            MEM_RE <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!FRAME_N) begin
                        if (addr_hit && (cmd_rd || cmd_wr)) begin
                            addr     <= {AD_IN[31:2], 2'b00};
                            is_read  <= cmd_rd;
                            DEVSEL_N <= 1'b0;
                            R_W      <= cmd_rd;
                            state    <= S_CLAIM;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    if (FRAME_N && IRDY_N) begin
                        state <= S_IDLE;
                    end
                end

                S_CLAIM: begin
                    if (is_read) begin
                        MEM_RE   <= 1'b1;
                        MEM_ADDR <= addr;
                        state    <= S_RWAIT;
                    end else begin
                        TRDY_N <= 1'b0;
`ifdef PCI_TGT_DISCONNECT_EN
                        if (cnt == LAST_M1) begin
                            STOP_N <= 1'b0;
                        end
`endif
                        state  <= S_WDATA;
                    end
                end

                S_WDATA: begin
                    if (xfer) begin
                        MEM_WE    <= 1'b1;
                        MEM_WDATA <= AD_IN;
                        MEM_BE    <= ~C_BE;
                        MEM_ADDR  <= addr;
                        addr      <= addr + 32'd4;
                        cnt       <= cnt_inc;
                        if (FRAME_N) begin
                            DEVSEL_N <= 1'b1;
                            TRDY_N   <= 1'b1;
                            STOP_N   <= 1'b1;
                            R_W      <= 1'b0;
                            state    <= S_TURN;
                        end
`ifdef PCI_TGT_DISCONNECT_EN
                        else if (!STOP_N) begin
                            TRDY_N <= 1'b1;
                            state  <= S_DISC;
                        end else if (cnt_inc == LAST_M1) begin
                            // Next phase is the last one allowed.
                            STOP_N <= 1'b0;
                        end
`endif
                    end else if (abort) begin
                        DEVSEL_N <= 1'b1;
                        TRDY_N   <= 1'b1;
                        STOP_N   <= 1'b1;
                        R_W      <= 1'b0;
                        state    <= S_TURN;
                    end
                end

                S_RWAIT: begin
                    RD_DATA <= MEM_RDATA;
                    TRDY_N  <= 1'b0;
`ifdef PCI_TGT_DISCONNECT_EN
                    if (cnt == LAST_M1) begin
                        STOP_N <= 1'b0;
                    end
`endif
                    state   <= S_RDATA;
                end

                S_RDATA: begin
                    if (xfer) begin
                        cnt    <= cnt_inc;
                        TRDY_N <= 1'b1;
                        if (FRAME_N) begin
                            DEVSEL_N <= 1'b1;
                            STOP_N   <= 1'b1;
                            R_W      <= 1'b0;
                            state    <= S_TURN;
                        end
`ifdef PCI_TGT_DISCONNECT_EN
                        else if (!STOP_N) begin
                            R_W   <= 1'b0;
                            state <= S_DISC;
                        end
`endif
                        else begin
                            addr     <= addr + 32'd4;
                            MEM_RE   <= 1'b1;
                            MEM_ADDR <= addr + 32'd4;
                            state    <= S_RWAIT;
                        end
                    end else if (abort) begin
                        DEVSEL_N <= 1'b1;
                        TRDY_N   <= 1'b1;
                        STOP_N   <= 1'b1;
                        R_W      <= 1'b0;
                        state    <= S_TURN;
                    end
                end

                // Disconnect pending: keep STOP_N low until the initiator
                // drops FRAME_N.
                S_DISC: begin
                    if (FRAME_N) begin
                        DEVSEL_N <= 1'b1;
                        TRDY_N   <= 1'b1;
                        STOP_N   <= 1'b1;
                        R_W      <= 1'b0;
                        state    <= S_TURN;
                    end
                end

                S_TURN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb_pci_target_ctrl
//   Directed bench for pci_target_ctrl with default parameters. The memory
//   model returns 0xA0 + word offset from 0x20 while MEM_RE is high, and 0
//   otherwise, so mistimed captures show up as wrong RD_DATA.

module tb_pci_target_ctrl;

    logic        CLK;
    logic        RST;
    logic        FRAME_N;
    logic        IRDY_N;
    logic [3:0]  C_BE;
    logic [31:0] AD_IN;
    logic        DEVSEL_N;
    logic        TRDY_N;
    logic        STOP_N;
    logic        R_W;
    logic [31:0] RD_DATA;
    logic [31:0] MEM_ADDR;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int both_cnt = 0;
    int we_base;
    int re_base;
    logic [31:0] last_we_addr = '0;

`ifdef PCI_TGT_DISCONNECT_EN
    localparam int          EXP_LONG_WE   = 8;
    localparam logic        EXP_STOP_P8   = 1'b0;
    localparam logic [31:0] EXP_LONG_LAST = 32'h0000_011C;
`else
    localparam int          EXP_LONG_WE   = 10;
    localparam logic        EXP_STOP_P8   = 1'b1;
    localparam logic [31:0] EXP_LONG_LAST = 32'h0000_0124;
`endif

    pci_target_ctrl #(
        .BASE_ADDR(32'h0000_0000),
        .DEC_BITS (20),
        .MAX_BURST(8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .FRAME_N  (FRAME_N),
        .IRDY_N   (IRDY_N),
        .C_BE     (C_BE),
        .AD_IN    (AD_IN),
        .DEVSEL_N (DEVSEL_N),
        .TRDY_N   (TRDY_N),
        .STOP_N   (STOP_N),
        .R_W      (R_W),
        .RD_DATA  (RD_DATA),
        .MEM_ADDR (MEM_ADDR),
        .MEM_WE   (MEM_WE),
        .MEM_RE   (MEM_RE),
        .MEM_BE   (MEM_BE),
        .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    assign MEM_RDATA = MEM_RE ? (32'h0000_00A0 + ((MEM_ADDR - 32'h20) >> 2)) : 32'h0;

    always @(negedge CLK) begin
        if (MEM_WE) begin
            we_cnt++;
            last_we_addr = MEM_ADDR;
        end
        if (MEM_RE) re_cnt++;
        if (MEM_WE && MEM_RE) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        FRAME_N = 1'b1;
        IRDY_N  = 1'b1;
        C_BE    = 4'hF;
        AD_IN   = 32'h0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
        FRAME_N = 1'b0;
        IRDY_N  = 1'b1;
        AD_IN   = a;
        C_BE    = cmd;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_devsel"}, DEVSEL_N, 1'b1);
        chk({pfx, "_trdy"},   TRDY_N,   1'b1);
        chk({pfx, "_stop"},   STOP_N,   1'b1);
        chk({pfx, "_rw"},     R_W,      1'b0);
        chk({pfx, "_rdata"},  RD_DATA,  32'h0);
        chk({pfx, "_maddr"},  MEM_ADDR, 32'h0);
        chk({pfx, "_we"},     MEM_WE,   1'b0);
        chk({pfx, "_re"},     MEM_RE,   1'b0);
        chk({pfx, "_be"},     MEM_BE,   4'h0);
        chk({pfx, "_wdata"},  MEM_WDATA, 32'h0);
    endtask

    initial begin
        RST = 1'b1;
        bus_idle();
        tick();
        tick();
        chk_reset_vals("rst");
        RST = 1'b0;
        tick();

        // Single write to 0x10
        we_base = we_cnt;
        addr_phase(32'h0000_0010, 4'b0111);
        tick();
        chk("w1_devsel", DEVSEL_N, 1'b0);
        chk("w1_trdy_claim", TRDY_N, 1'b1);
        chk("w1_rw_claim", R_W, 1'b0);
        FRAME_N = 1'b1; IRDY_N = 1'b0; AD_IN = 32'hDEAD_BEEF; C_BE = 4'b0000;
        tick();
        chk("w1_trdy", TRDY_N, 1'b0);
        chk("w1_we_early", MEM_WE, 1'b0);
        tick();
        chk("w1_we", MEM_WE, 1'b1);
        chk("w1_addr", MEM_ADDR, 32'h0000_0010);
        chk("w1_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        chk("w1_be", MEM_BE, 4'hF);
        chk("w1_turn_devsel", DEVSEL_N, 1'b1);
        chk("w1_turn_trdy", TRDY_N, 1'b1);
        chk("w1_rw", R_W, 1'b0);
        bus_idle();
        tick();
        chk("w1_we_off", MEM_WE, 1'b0);
        tick();
        chk("w1_pulses", we_cnt - we_base, 1);

        // Read burst of 3 from 0x20
        re_base = re_cnt;
        addr_phase(32'h0000_0020, 4'b0110);
        tick();
        chk("r_devsel", DEVSEL_N, 1'b0);
        chk("r_rw_claim", R_W, 1'b1);
        FRAME_N = 1'b0; IRDY_N = 1'b0; C_BE = 4'b0000; AD_IN = 32'h0;
        for (int p = 0; p < 3; p++) begin
            tick();
            chk($sformatf("r_re%0d", p), MEM_RE, 1'b1);
            chk($sformatf("r_addr%0d", p), MEM_ADDR, 32'h20 + 32'(p * 4));
            chk($sformatf("r_trdy_wait%0d", p), TRDY_N, 1'b1);
            if (p == 2) FRAME_N = 1'b1;
            tick();
            chk($sformatf("r_data%0d", p), RD_DATA, 32'hA0 + 32'(p));
            chk($sformatf("r_trdy%0d", p), TRDY_N, 1'b0);
            chk($sformatf("r_rw%0d", p), R_W, 1'b1);
        end
        tick();
        chk("r_end_rw", R_W, 1'b0);
        chk("r_end_devsel", DEVSEL_N, 1'b1);
        chk("r_end_trdy", TRDY_N, 1'b1);
        bus_idle();
        tick();
        chk("r_pulses", re_cnt - re_base, 3);

        // Misses: out-of-window, window edge, non-memory command
        we_base = we_cnt;
        re_base = re_cnt;
        addr_phase(32'h1000_0000, 4'b0111);
        tick();
        chk("miss_devsel", DEVSEL_N, 1'b1);
        FRAME_N = 1'b1; IRDY_N = 1'b0; AD_IN = 32'h1234_5678; C_BE = 4'b0000;
        tick();
        // Still BUSY while IRDY_N low: a hit-looking frame must be ignored.
        addr_phase(32'h0000_0010, 4'b0111);
        IRDY_N = 1'b0;
        tick();
        chk("busy_hold_devsel", DEVSEL_N, 1'b1);
        bus_idle();
        tick();
        addr_phase(32'h0000_1000, 4'b0110);
        tick();
        chk("edge_miss_devsel", DEVSEL_N, 1'b1);
        bus_idle();
        tick();
        addr_phase(32'h0000_0010, 4'b0010);
        tick();
        chk("io_miss_devsel", DEVSEL_N, 1'b1);
        bus_idle();
        tick();
        tick();
        chk("miss_we", we_cnt - we_base, 0);
        chk("miss_re", re_cnt - re_base, 0);

        // Write burst with a 2-cycle initiator wait
        addr_phase(32'h0000_0040, 4'b0111);
        tick();
        FRAME_N = 1'b0; IRDY_N = 1'b0; AD_IN = 32'h1111_0000; C_BE = 4'b0000;
        tick();
        tick();
        chk("wt_we0", MEM_WE, 1'b1);
        chk("wt_addr0", MEM_ADDR, 32'h40);
        chk("wt_data0", MEM_WDATA, 32'h1111_0000);
        IRDY_N = 1'b1; AD_IN = 32'hBAD0_BAD0;
        tick();
        chk("wt_wait1_we", MEM_WE, 1'b0);
        chk("wt_wait1_addr", MEM_ADDR, 32'h40);
        tick();
        chk("wt_wait2_we", MEM_WE, 1'b0);
        chk("wt_wait2_addr", MEM_ADDR, 32'h40);
        chk("wt_wait2_devsel", DEVSEL_N, 1'b0);
        IRDY_N = 1'b0; FRAME_N = 1'b1; AD_IN = 32'h2222_0001; C_BE = 4'b0011;
        tick();
        chk("wt_we1", MEM_WE, 1'b1);
        chk("wt_addr1", MEM_ADDR, 32'h44);
        chk("wt_data1", MEM_WDATA, 32'h2222_0001);
        chk("wt_be1", MEM_BE, 4'b1100);
        chk("wt_devsel_off", DEVSEL_N, 1'b1);
        bus_idle();
        tick();

        // Reset during read burst at phase 2, then a normal write
        addr_phase(32'h0000_0020, 4'b0110);
        tick();
        FRAME_N = 1'b0; IRDY_N = 1'b0; C_BE = 4'b0000; AD_IN = 32'h0;
        tick();
        tick();
        tick();
        tick();
        chk("rr_phase2_data", RD_DATA, 32'hA1);
        RST = 1'b1;
        tick();
        chk_reset_vals("rr");
        RST = 1'b0;
        bus_idle();
        tick();
        addr_phase(32'h0000_0080, 4'b0111);
        tick();
        chk("rr_w_devsel", DEVSEL_N, 1'b0);
        FRAME_N = 1'b1; IRDY_N = 1'b0; AD_IN = 32'h5A5A_5A5A; C_BE = 4'b0000;
        tick();
        tick();
        chk("rr_w_we", MEM_WE, 1'b1);
        chk("rr_w_addr", MEM_ADDR, 32'h80);
        chk("rr_w_data", MEM_WDATA, 32'h5A5A_5A5A);
        bus_idle();
        tick();

        // Last word of window; burst continues past it unchecked
        addr_phase(32'h0000_0FFC, 4'b0111);
        tick();
        chk("edge_devsel", DEVSEL_N, 1'b0);
        FRAME_N = 1'b0; IRDY_N = 1'b0; AD_IN = 32'hC0C0_0001; C_BE = 4'b0000;
        tick();
        tick();
        chk("edge_addr0", MEM_ADDR, 32'h0000_0FFC);
        FRAME_N = 1'b1; AD_IN = 32'hC0C0_0002;
        tick();
        chk("edge_addr1", MEM_ADDR, 32'h0000_1000);
        chk("edge_data1", MEM_WDATA, 32'hC0C0_0002);
        bus_idle();
        tick();

        // 10-phase write burst
        we_base = we_cnt;
        addr_phase(32'h0000_0100, 4'b0111);
        tick();
        FRAME_N = 1'b0; IRDY_N = 1'b0; C_BE = 4'b0000;
        AD_IN = 32'h100;
        tick();
        for (int i = 0; i < 10; i++) begin
            AD_IN   = 32'h100 + 32'(i);
            FRAME_N = (i == 9);
            tick();
            if (i == 6) chk("long_stop_p8", STOP_N, EXP_STOP_P8);
        end
        bus_idle();
        tick();
        tick();
        chk("long_pulses", we_cnt - we_base, EXP_LONG_WE);
        chk("long_last_addr", last_we_addr, EXP_LONG_LAST);
        chk("long_devsel", DEVSEL_N, 1'b1);
        chk("long_stop_end", STOP_N, 1'b1);

        chk("strobe_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pci_target_ctrl.md
Name: pci_target_ctrl

Overview:
- PCI target-side transaction controller for single- and burst-memory cycles; sits directly upstream of the AD bus buffer and drives its read/write select.
- Decodes the address phase and drives DEVSEL_N/TRDY_N/STOP_N.
- Produces the target-drive select R_W and the read-data word that the buffer places on AD.
- Sequences a synchronous word memory: write data comes from the bus side, read data goes back to the bus side.

Parameters:
- BASE_ADDR, 32'h0000_0000, base byte address of the target window.
- DEC_BITS, 20, number of upper address bits compared against BASE_ADDR (window = 2^(32-DEC_BITS) bytes).
- MAX_BURST, 8, data phases allowed before target disconnect (used only with the optional feature).

Ports:
- CLK in 1: PCI clock; all logic on rising edge.
- RST in 1: synchronous, active-high reset.
- FRAME_N in 1: initiator frame, active low.
- IRDY_N in 1: initiator ready, active low.
- C_BE in 4: command in the address phase; active-low byte enables in data phases.
- AD_IN in 32: AD bus as seen by the target.
- DEVSEL_N out 1: device select, active low.
- TRDY_N out 1: target ready, active low.
- STOP_N out 1: target stop, active low.
- R_W out 1: 1 = target drives AD (read command data phases); 0 = bus to memory.
- RD_DATA out 32: word for the buffer to drive onto AD.
- MEM_ADDR out 32: word-aligned byte address to memory.
- MEM_WE out 1: one-cycle write strobe.
- MEM_RE out 1: one-cycle read strobe; memory returns MEM_RDATA on the next edge.
- MEM_BE out 4: active-high byte enables, equal to ~C_BE.
- MEM_WDATA out 32: write data.
- MEM_RDATA in 32: memory read data.

Behaviour:
- Reset values: DEVSEL_N=1, TRDY_N=1, STOP_N=1, R_W=0, RD_DATA=0, MEM_ADDR=0, MEM_WE=0, MEM_RE=0, MEM_BE=0, MEM_WDATA=0, state=IDLE, burst count=0. RST asserted in any state returns all of these at the next edge, including mid-burst.
- Hit condition: AD_IN[31:32-DEC_BITS] == BASE_ADDR[31:32-DEC_BITS] and C_BE is 4'b0110 (memory read) or 4'b0111 (memory write). Other commands are never claimed.
- Transfer condition: IRDY_N==0 && TRDY_N==0 on a rising edge.
- IDLE:
  - FRAME_N==0 with a hit: latch {AD_IN[31:2],2'b00} into the address register, latch the command, go to CLAIM.
  - FRAME_N==0 with no hit: go to BUSY.
- BUSY: wait until FRAME_N==1 && IRDY_N==1, then go to IDLE.
- CLAIM: DEVSEL_N=0.
  - Write command: TRDY_N=0, go to WDATA.
  - Read command: R_W=1, MEM_RE=1 at the latched address, go to RWAIT.
- WDATA: on each transfer, MEM_WE=1 for one cycle, MEM_WDATA=AD_IN, MEM_BE=~C_BE, MEM_ADDR=current address; then address += 4.
  - If FRAME_N==1 at the transfer (last phase): TRDY_N=1, go to TURN.
  - No transfer: hold all outputs; MEM_WE=0.
- RWAIT: TRDY_N=1; capture RD_DATA=MEM_RDATA; go to RDATA.
- RDATA: TRDY_N=0.
  - On transfer with FRAME_N==0: address += 4, MEM_RE=1 at the new address, go to RWAIT. This gives one wait state per read phase.
  - On transfer with FRAME_N==1: go to TURN.
- Master abort: in WDATA or RDATA, FRAME_N==1 && IRDY_N==1 without a transfer goes to TURN.
- TURN: DEVSEL_N=1, TRDY_N=1, STOP_N=1, R_W=0; next cycle IDLE. TURN lasts one cycle; a new FRAME_N is not decoded until IDLE.
- Address wrap: 32'hFFFF_FFFC + 4 wraps to 0. No window check after the address phase.
- MEM_WE and MEM_RE are never high in the same cycle.

Optional Feature:
- Macro: PCI_TGT_DISCONNECT_EN.
- With the macro: count transfers per transaction. On the phase where count reaches MAX_BURST, assert STOP_N=0 together with TRDY_N=0 (disconnect with data).
  - After that transfer, TRDY_N=1 and STOP_N stays 0 until FRAME_N==1, then go to TURN.
  - If FRAME_N is already 1 at that transfer, go straight to TURN.
- Without the macro: STOP_N is constant 1, bursts are unbounded, MAX_BURST is unused.

Test Plan:
- Single write: address phase AD_IN=32'h0000_0010, C_BE=0111, FRAME_N deasserted with IRDY_N=0 on the data phase carrying AD_IN=32'hDEAD_BEEF, C_BE=0000 -> DEVSEL_N low one cycle after the address phase; one MEM_WE pulse with MEM_ADDR=0x10, MEM_WDATA=DEADBEEF, MEM_BE=1111; TURN then IDLE with R_W=0 throughout.
- Read burst of 3 from 0x20, memory returning 0xA0/0xA1/0xA2 -> R_W=1 from CLAIM to the last phase; MEM_RE at 0x20, 0x24, 0x28; RD_DATA=A0, A1, A2 presented with TRDY_N=0 on alternating cycles.
- Miss: address 32'h1000_0000, C_BE=0111 -> DEVSEL_N stays 1; BUSY until FRAME_N and IRDY_N are both high; no MEM strobes.
- Initiator wait: write burst with IRDY_N=1 for 2 cycles mid-burst -> no MEM_WE during the wait; address unchanged; resumes at the next word.
- RST high during a read burst at phase 2 -> all outputs at reset values next edge; a following valid write decodes normally.
- With PCI_TGT_DISCONNECT_EN and MAX_BURST=8: 10-phase write -> 8 MEM_WE pulses; STOP_N=0 on phase 8; TRDY_N=1 afterwards; IDLE after FRAME_N rises.
